lcd_bus_writer: RTL and testbench
=================================

Name: lcd_bus_writer

Overview:
- Hardware writer for the 8-bit character-LCD bus on the DE2 board.
- Takes command/data bytes over a valid/ready handshake and drives EN/RS/RW/DATA with correct setup, pulse, hold and execution-wait timing.
- Output uses the same 32-bit io_lcd word layout the top level already decodes onto LCD_* pins: [31]=ON, [10]=EN, [9]=RS, [8]=RW, [7:0]=DATA.
- Replaces software bit-banging, so the CPU does not poll delay loops.

Parameters:
- T_SETUP, 2: cycles RS/DATA are stable before EN rises (40 ns at 50 MHz).
- T_PULSE, 12: cycles EN is held high (240 ns).
- T_HOLD, 2: cycles RS/DATA are held after EN falls.
- T_EXEC, 2000: wait cycles after a normal command or data byte (40 us).
- T_EXEC_LONG, 82000: wait cycles after clear/home (1.64 ms).
- T_PWRUP, 750000: power-up wait before the init sequence (15 ms). Used only with the optional feature.

Ports:
- i_clk, input, 1: system clock (50 MHz).
- i_rst, input, 1: asynchronous reset, active-high.
- i_valid, input, 1: request valid.
- o_ready, output, 1: writer can accept a request.
- i_rs, input, 1: 0 = command, 1 = character data.
- i_data, input, 8: byte to write.
- i_lcd_on, input, 1: LCD power enable, registered into bit 31.
- o_busy, output, 1: a transfer or its wait is in progress.
- o_io_lcd, output, 32: LCD bus word; unused bits are 0.

Behaviour:
- Reset:
  - Async assert clears o_io_lcd to 0 (EN low immediately), o_ready=0, o_busy=0, all counters to 0.
  - First clock after deassert: o_ready=1 (or init starts under the optional feature).
- Reset during any state aborts the transfer. No partial EN pulse survives reset.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. One down-counter, width $clog2(max param + 1).
- Handshake:
  - o_ready=1 only in IDLE.
  - Accept on the rising edge where i_valid & o_ready; latch i_rs and i_data.
  - i_valid while busy is ignored; no queueing.
  - The requester must hold i_valid until it sees ready.
- Transfer sequence after acceptance at edge N:
  - Edge N: go to SETUP. RS=i_rs, DATA=i_data, RW=0, EN=0; load T_SETUP-1.
  - SETUP lasts T_SETUP cycles, then PULSE: EN=1 for exactly T_PULSE cycles.
  - HOLD: EN=0, RS/DATA unchanged, T_HOLD cycles.
  - WAIT: T_EXEC cycles, or T_EXEC_LONG when rs=0 and data[7:2]==0 (0x00–0x03: clear/home), then IDLE.
  - Accept to ready = T_SETUP+T_PULSE+T_HOLD+wait cycles.
- Output stability:
  - RS and DATA keep their last value after the transfer until the next acceptance.
  - RW is always 0; this block never reads the busy flag.
- Bit 31 is registered from i_lcd_on every cycle, independent of FSM state.
- o_busy = (state != IDLE). Under the optional feature it is also high during the power-up wait and init.
- Back-to-back: with i_valid held high, a new acceptance occurs on the first IDLE cycle, so there is exactly one ready cycle between transfers.
- Counter loads use param-1, so each phase lasts exactly its param count. Params of 0 are illegal.

Optional Feature:
- Macro: LCD_WRITER_INIT_EN.
- Defined:
  - After reset, wait T_PWRUP cycles.
  - Then autonomously send commands 0x38, 0x0C, 0x01, 0x06 through the same SETUP/PULSE/HOLD/WAIT path. The 0x01 uses T_EXEC_LONG.
  - o_ready=0 and o_busy=1 until the sequence completes; i_valid is ignored meanwhile.
  - Reset mid-init restarts from the power-up wait.
- Undefined: no init logic or ROM; ready one cycle after reset release.

Test Plan (T_SETUP=2, T_PULSE=4, T_HOLD=2, T_EXEC=10, T_EXEC_LONG=50, T_PWRUP=20):
- Reset release, no request -> o_io_lcd=0, o_ready=1 next cycle, o_busy=0.
- Pulse i_valid with rs=1, data=0x41 -> RS=1, DATA=0x41 from next edge; EN high exactly 4 cycles starting 2 cycles later; o_ready back high 18 cycles after acceptance.
- Command rs=0, data=0x01 -> EN pulse as above; o_ready returns 58 cycles after acceptance. data=0x38 returns after 18.
- i_valid held high with bytes 0x48, 0x49 -> two transfers; the second is accepted on the first IDLE cycle; exactly 2 EN pulses, no overlap.
- Assert i_rst during PULSE -> EN drops to 0 the same cycle (async); o_io_lcd=0; no further EN pulse after release.
- LCD_WRITER_INIT_EN defined: after reset, o_ready stays 0 for 20 cycles, then EN pulses carry 0x38, 0x0C, 0x01, 0x06 with RS=0; o_ready rises after 20+18+18+58+18 cycles; i_valid pulsed during init is ignored.

Source files
------------

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: drives the DE2 8-bit character-LCD bus (EN/RS/RW/DATA) from
// a valid/ready byte interface, generating setup, EN pulse, hold and the
// controller's execution wait so software never has to spin in delay loops.
// Output word layout: [31]=ON, [10]=EN, [9]=RS, [8]=RW, [7:0]=DATA.
// Optional feature macro: LCD_WRITER_INIT_EN (power-up wait plus autonomous
// init sequence 0x38, 0x0C, 0x01, 0x06 before the first request is taken).
module lcd_bus_writer #(
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000,
    parameter int T_PWRUP     = 750000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_rs,
    input  logic [7:0]  i_data,
    input  logic        i_lcd_on,
    output logic        o_busy,
    output logic [31:0] o_io_lcd
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(T_SETUP, T_PULSE), max2(T_HOLD, T_EXEC)),
                                  max2(T_EXEC_LONG, T_PWRUP));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;
`ifdef LCD_WRITER_INIT_EN
    localparam logic [2:0] ST_PWRUP = 3'd5;
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
`endif

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             armed;
    logic             en_q;
    logic             rs_q;
    logic [7:0]       data_q;
    logic             on_q;
    logic             accept;
    logic             long_wait;

`ifdef LCD_WRITER_INIT_EN
    logic       init_active;
    logic [1:0] init_idx;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    // Handshake and status decode; armed keeps ready/busy low until the first clock after reset.
    always_comb begin
        o_ready   = armed && (state == ST_IDLE);
        o_busy    = armed && (state != ST_IDLE);
        accept    = i_valid && o_ready;
        long_wait = !rs_q && (data_q[7:2] == 6'd0);
    end

    // Transfer sequencer: one down-counter reloaded with (phase length - 1) on every phase change.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
`ifdef LCD_WRITER_INIT_EN
            state       <= ST_PWRUP;
            init_active <= 1'b1;
            init_idx    <= 2'd0;
`else
            state       <= ST_IDLE;
`endif
            cnt    <= '0;
            armed  <= 1'b0;
            en_q   <= 1'b0;
            rs_q   <= 1'b0;
            data_q <= 8'h00;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state  <= ST_SETUP;
                        cnt    <= LD_SETUP;
                        rs_q   <= i_rs;
                        data_q <= i_data;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        state <= ST_PULSE;
                        cnt   <= LD_PULSE;
                        en_q  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state <= ST_HOLD;
                        cnt   <= LD_HOLD;
                        en_q  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state <= ST_WAIT;
                        cnt   <= long_wait ? LD_LONG : LD_EXEC;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
`ifdef LCD_WRITER_INIT_EN
                        if (init_active && (init_idx != 2'd3)) begin
                            init_idx <= init_idx + 2'd1;
                            state    <= ST_SETUP;
                            cnt      <= LD_SETUP;
                            rs_q     <= 1'b0;
                            data_q   <= init_cmd(init_idx + 2'd1);
                        end else begin
                            init_active <= 1'b0;
                            state       <= ST_IDLE;
                        end
`else
                        state <= ST_IDLE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef LCD_WRITER_INIT_EN
                ST_PWRUP: begin
                    if (!armed) begin
                        cnt <= LD_PWRUP;
                    end else if (cnt == '0) begin
                        state  <= ST_SETUP;
                        cnt    <= LD_SETUP;
                        rs_q   <= 1'b0;
                        data_q <= init_cmd(2'd0);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    en_q  <= 1'b0;
                end
            endcase
        end
    end

    // LCD power bit follows i_lcd_on one cycle later regardless of the sequencer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            on_q <= 1'b0;
        end else begin
            on_q <= i_lcd_on;
        end
    end

    assign o_io_lcd = {on_q, 20'd0, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: table-driven transfer timing checks, hand-written corner
// sequences (back-to-back, reset during EN pulse) and a randomized run checked
// against a transfer-age reference model.
module tb_lcd_bus_writer;

    localparam int T_SETUP     = 2;
    localparam int T_PULSE     = 4;
    localparam int T_HOLD      = 2;
    localparam int T_EXEC      = 10;
    localparam int T_EXEC_LONG = 50;
    localparam int T_PWRUP     = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        rs;
    logic [7:0]  data;
    logic        lcd_on;
    logic        ready;
    logic        busy;
    logic [31:0] io;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: a transfer is described only by its age in cycles since acceptance.
    logic       m_armed;
    logic       m_busy;
    logic       m_rs;
    logic       m_on;
    logic [7:0] m_data;
    int         m_age;
    int         m_total;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         cycles;
    } vec_t;

    vec_t vecs[8];

    lcd_bus_writer #(
        .T_SETUP    (T_SETUP),
        .T_PULSE    (T_PULSE),
        .T_HOLD     (T_HOLD),
        .T_EXEC     (T_EXEC),
        .T_EXEC_LONG(T_EXEC_LONG),
        .T_PWRUP    (T_PWRUP)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .o_ready (ready),
        .i_rs    (rs),
        .i_data  (data),
        .i_lcd_on(lcd_on),
        .o_busy  (busy),
        .o_io_lcd(io)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic r, input logic [7:0] d, input logic on);
        valid  = v;
        rs     = r;
        data   = d;
        lcd_on = on;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady(input string name);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        checkOutput(name, {31'd0, ready}, 32'd1);
    endtask

    function automatic int waitFor(input logic r, input logic [7:0] d);
        return (!r && d < 8'd4) ? T_EXEC_LONG : T_EXEC;
    endfunction

    task automatic modelReset();
        m_armed = 1'b0;
        m_busy  = 1'b0;
        m_rs    = 1'b0;
        m_on    = 1'b0;
        m_data  = 8'h00;
        m_age   = 0;
        m_total = 0;
    endtask

    task automatic modelEdge();
        logic was_ready;
        was_ready = m_armed && !m_busy;
        if (was_ready && valid) begin
            m_busy  = 1'b1;
            m_age   = 0;
            m_rs    = rs;
            m_data  = data;
            m_total = T_SETUP + T_PULSE + T_HOLD + waitFor(rs, data);
        end else if (m_busy) begin
            m_age++;
            if (m_age >= m_total) m_busy = 1'b0;
        end
        m_armed = 1'b1;
        m_on    = lcd_on;
    endtask

    function automatic logic [31:0] modelIo();
        logic en;
        en = m_busy && (m_age >= T_SETUP) && (m_age < T_SETUP + T_PULSE);
        return {m_on, 20'd0, en, m_rs, 1'b0, m_data};
    endfunction

    // Global time limit so a stuck design still ends the run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        int k;
        int en_first;
        int en_cnt;
        int first_ready_k;
        int ready_cnt;
        int pulses;
        logic prev_en;
        logic done;
        logic [7:0] pulse_data [2];

        vecs[0] = '{1'b1, 8'h41, 18};
        vecs[1] = '{1'b0, 8'h01, 58};
        vecs[2] = '{1'b0, 8'h38, 18};
        vecs[3] = '{1'b0, 8'h00, 58};
        vecs[4] = '{1'b0, 8'h03, 58};
        vecs[5] = '{1'b0, 8'h04, 18};
        vecs[6] = '{1'b1, 8'h02, 18};
        vecs[7] = '{1'b0, 8'h02, 58};

        // Reset and release with no request.
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        checkOutput("reset_io", io, 32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("release_ready_before_edge", {31'd0, ready}, 32'd0);
        tick();
        checkOutput("release_ready", {31'd0, ready}, 32'd1);
        checkOutput("release_busy", {31'd0, busy}, 32'd0);
        checkOutput("release_io", io, 32'd0);

        // Table-driven single transfers: RS/DATA timing, EN window, accept-to-ready latency.
        for (int i = 0; i < 8; i++) begin
            waitReady("vec_pre_ready");
            applyStimulus(1'b1, vecs[i].rs, vecs[i].data, 1'b1);
            tick();
            applyStimulus(1'b0, ~vecs[i].rs, ~vecs[i].data, 1'b1);
            checkOutput("vec_rs_data", {22'd0, io[9:0]}, {22'd0, 1'b0, vecs[i].rs, 1'b0, vecs[i].data});
            checkOutput("vec_busy", {31'd0, busy}, 32'd1);
            k = 0;
            en_first = -1;
            en_cnt = 0;
            done = 1'b0;
            while (!done && k < 200) begin
                if (io[10]) begin
                    if (en_cnt == 0) en_first = k;
                    en_cnt++;
                end
                if (ready) done = 1'b1;
                else begin
                    tick();
                    k++;
                end
            end
            checkOutput("vec_en_start", en_first, T_SETUP);
            checkOutput("vec_en_len", en_cnt, T_PULSE);
            checkOutput("vec_latency", k, vecs[i].cycles);
            checkOutput("vec_hold_rs_data", {22'd0, io[9:0]}, {22'd0, 1'b0, vecs[i].rs, 1'b0, vecs[i].data});
            checkOutput("vec_on_bit", {31'd0, io[31]}, 32'd1);
        end

        // Back-to-back with i_valid held high: second byte taken on the first IDLE cycle.
        waitReady("b2b_pre_ready");
        applyStimulus(1'b1, 1'b1, 8'h48, 1'b1);
        tick();
        data = 8'h49;
        k = 0;
        pulses = 0;
        ready_cnt = 0;
        first_ready_k = -1;
        prev_en = 1'b0;
        done = 1'b0;
        pulse_data[0] = 8'h00;
        pulse_data[1] = 8'h00;
        while (!done && k < 200) begin
            if (io[10] && !prev_en) begin
                if (pulses < 2) pulse_data[pulses] = io[7:0];
                pulses++;
            end
            prev_en = io[10];
            if (ready) begin
                ready_cnt++;
                if (ready_cnt == 1) first_ready_k = k;
                else done = 1'b1;
            end
            if (!done) begin
                tick();
                k++;
                if (ready_cnt == 1) valid = 1'b0;
            end
        end
        checkOutput("b2b_first_ready", first_ready_k, 18);
        checkOutput("b2b_second_ready", k, 37);
        checkOutput("b2b_pulses", pulses, 2);
        checkOutput("b2b_data0", {24'd0, pulse_data[0]}, 32'h48);
        checkOutput("b2b_data1", {24'd0, pulse_data[1]}, 32'h49);

        // Reset asserted in the middle of the EN pulse.
        waitReady("rst_pre_ready");
        applyStimulus(1'b1, 1'b1, 8'h55, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 8'h55, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("rst_en_before", {31'd0, io[10]}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_io", io, 32'd0);
        checkOutput("rst_async_ready", {31'd0, ready}, 32'd0);
        checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        en_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (io[10]) en_cnt++;
        end
        checkOutput("rst_no_en_after", en_cnt, 0);
        checkOutput("rst_ready_after", {31'd0, ready}, 32'd1);
        checkOutput("rst_bus_after", {22'd0, io[9:0]}, 32'd0);

        // Randomized traffic against the reference model, starting from a fresh reset.
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        modelReset();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            logic v;
            logic r;
            logic [7:0] d;
            logic on;
            v  = ($urandom_range(0, 3) != 0);
            r  = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            on = ($urandom_range(0, 7) != 0);
            applyStimulus(v, r, d, on);
            @(posedge clk);
            modelEdge();
            #1;
            checkOutput("rand_io", io, modelIo());
            checkOutput("rand_ready", {31'd0, ready}, {31'd0, m_armed && !m_busy});
            checkOutput("rand_busy", {31'd0, busy}, {31'd0, m_busy});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
